// File: rtl/voice_emph_pkg.sv
// voice_emph_pkg: shared constants for the emphasis filter.
//   EMPH_*       mode encodings (2'b11 decodes as bypass)
//   round_const  half-LSB added before the Q1.(COEF_WIDTH-1) rescale shift
//   sat_hi/lo    signed saturation limits for a given sample width
package voice_emph_pkg;

  localparam logic [1:0] EMPH_BYPASS = 2'b00;
  localparam logic [1:0] EMPH_PRE    = 2'b01;
  localparam logic [1:0] EMPH_DE     = 2'b10;

  function automatic longint round_const(input int coef_w);
    return longint'(1) <<< (coef_w - 2);
  endfunction

  function automatic longint sat_hi(input int data_w);
    return (longint'(1) <<< (data_w - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int data_w);
    return -(longint'(1) <<< (data_w - 1));
  endfunction

endpackage

// File: rtl/emph_mac.sv
// emph_mac: two-stage shared datapath.
//   stage 1 (in_*_i): registers p = a*hist at full width, x, channel, mode
//   stage 2: round p, add/sub against x, saturate; registers data_o/ch_o/vld_o
//   s2_*/wb_*: combinational stage-2 view used for history write-back and
//              forwarding in the parent
module emph_mac
  import voice_emph_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int CH_W       = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_vld_i,
  input  logic [CH_W-1:0]              in_ch_i,
  input  logic [1:0]                   in_mode_i,
  input  logic signed [DATA_WIDTH-1:0] in_x_i,
  input  logic signed [DATA_WIDTH-1:0] in_hist_i,
  input  logic [COEF_WIDTH-1:0]        coef_i,
  output logic                         s2_vld_o,
  output logic [CH_W-1:0]              s2_ch_o,
  output logic                         wb_en_o,
  output logic signed [DATA_WIDTH-1:0] wb_val_o,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic [CH_W-1:0]              ch_o,
  output logic                         vld_o
);

  localparam int STAGES = 2;
  localparam int PW     = DATA_WIDTH + COEF_WIDTH + 1;
  // x +/- q needs two guard bits before the clamp
  localparam int SW     = DATA_WIDTH + 2;
  localparam logic signed [PW-1:0] RND    = PW'(round_const(COEF_WIDTH));
  localparam logic signed [SW-1:0] SAT_HI = SW'(sat_hi(DATA_WIDTH));
  localparam logic signed [SW-1:0] SAT_LO = SW'(sat_lo(DATA_WIDTH));

  logic [STAGES:1]              vld_pipe_q;
  logic [CH_W-1:0]              ch1_q, ch2_q;
  logic [1:0]                   mode1_q;
  logic signed [DATA_WIDTH-1:0] x1_q, y2_q;
  logic signed [PW-1:0]         p1_q;

  logic signed [PW-1:0]         prod_d;
  logic signed [SW-1:0]         q_d, x_ext, sum_d;
  logic signed [DATA_WIDTH-1:0] y_d;

  // coefficient is unsigned: zero-extend so it is never read as negative
  assign prod_d = $signed({{(PW-DATA_WIDTH){in_hist_i[DATA_WIDTH-1]}}, in_hist_i})
                * $signed({{(PW-COEF_WIDTH){1'b0}}, coef_i});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      ch1_q      <= '0;
      mode1_q    <= EMPH_BYPASS;
      x1_q       <= '0;
      p1_q       <= '0;
      ch2_q      <= '0;
      y2_q       <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_vld_i};
      if (in_vld_i) begin
        ch1_q   <= in_ch_i;
        mode1_q <= in_mode_i;
        x1_q    <= in_x_i;
        p1_q    <= prod_d;
      end
      if (vld_pipe_q[1]) begin
        ch2_q <= ch1_q;
        y2_q  <= y_d;
      end
    end
  end

  always_comb begin
    // |q| < 2^(DATA_WIDTH-1)+1, so truncation to SW bits is lossless
    q_d   = SW'((p1_q + RND) >>> (COEF_WIDTH - 1));
    x_ext = {{2{x1_q[DATA_WIDTH-1]}}, x1_q};
    case (mode1_q)
      EMPH_PRE: sum_d = x_ext - q_d;
      EMPH_DE:  sum_d = x_ext + q_d;
      default:  sum_d = x_ext;
    endcase
    if (sum_d > SAT_HI)      y_d = SAT_HI[DATA_WIDTH-1:0];
    else if (sum_d < SAT_LO) y_d = SAT_LO[DATA_WIDTH-1:0];
    else                     y_d = sum_d[DATA_WIDTH-1:0];
  end

  assign s2_vld_o = vld_pipe_q[1];
  assign s2_ch_o  = ch1_q;
  assign wb_en_o  = vld_pipe_q[1] && (mode1_q == EMPH_PRE || mode1_q == EMPH_DE);
  // pre-emphasis remembers the input, de-emphasis the (clamped) output
  assign wb_val_o = (mode1_q == EMPH_PRE) ? x1_q : y_d;

  assign data_o = y2_q;
  assign ch_o   = ch2_q;
  assign vld_o  = vld_pipe_q[STAGES];

endmodule

// File: rtl/voice_emph_filter.sv
// voice_emph_filter: multi-channel first-order emphasis filter
// (bypass / pre-emphasis / de-emphasis) over one shared MAC pipeline.
//   sck, voide_rst_n      clock, async active-low reset
//   data_in/in_vld        packed per-channel samples and strobes
//   cfg_load/mode/coef    shadowed configuration, committed when idle
//   data_out/out_vld/ch   filtered sample, two cycles after grant
//   busy                  any sample pending or in the pipeline
//   ovf_err               sticky: a sample was dropped
module voice_emph_filter
  import voice_emph_pkg::*;
#(
  parameter int          DATA_WIDTH = 16,
  parameter int          COEF_WIDTH = 16,
  parameter int          CH_NUM     = 2,
  parameter int unsigned COEF_RST   = 32113,
  localparam int         CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                           sck,
  input  logic                           voide_rst_n,
  input  logic [CH_NUM*DATA_WIDTH-1:0]   data_in,
  input  logic [CH_NUM-1:0]              in_vld,
  input  logic                           cfg_load,
  input  logic [1:0]                     cfg_mode,
  input  logic [COEF_WIDTH-1:0]          cfg_coef,
  output logic signed [DATA_WIDTH-1:0]   data_out,
  output logic                           out_vld,
  output logic [CH_W-1:0]                out_ch,
  output logic                           busy,
  output logic                           ovf_err
);

  localparam int DW = DATA_WIDTH;
  localparam logic [COEF_WIDTH-1:0] COEF_RST_W = COEF_WIDTH'(COEF_RST);

  logic [CH_NUM-1:0]      pend_q, req, gnt_oh, take, drop;
  logic signed [DW-1:0]   samp_q [CH_NUM];
  logic signed [DW-1:0]   hist_q [CH_NUM];
  logic signed [DW-1:0]   x_in   [CH_NUM];
  logic                   gnt_vld;
  logic [CH_W-1:0]        gnt_ch;
  logic signed [DW-1:0]   gnt_x, gnt_hist;

  logic [1:0]             mode_q, sh_mode_q;
  logic [COEF_WIDTH-1:0]  coef_q, sh_coef_q;
  logic                   sh_pend_q, ovf_q, commit;

  logic                   s2_vld, wb_en;
  logic [CH_W-1:0]        s2_ch;
  logic signed [DW-1:0]   wb_val;

  always_comb begin
    for (int c = 0; c < CH_NUM; c++) x_in[c] = data_in[c*DW +: DW];
  end

  // fixed priority: lowest channel index wins
  assign req     = pend_q | in_vld;
  assign gnt_vld = |req;
  assign gnt_oh  = req & (~req + CH_NUM'(1));

  always_comb begin
    gnt_ch = '0;
    for (int c = CH_NUM-1; c >= 0; c--) if (req[c]) gnt_ch = CH_W'(c);
  end

  // a held sample is older than one arriving now, so it goes first
  assign gnt_x    = pend_q[gnt_ch] ? samp_q[gnt_ch] : x_in[gnt_ch];
  // stage 2 writes this channel's history at the same edge we capture it
  assign gnt_hist = (wb_en && s2_ch == gnt_ch) ? wb_val : hist_q[gnt_ch];

  // accept unless the slot is occupied and not being freed this cycle
  assign drop = in_vld & pend_q & ~gnt_oh;
  assign take = in_vld & ~drop;

  assign busy   = (|pend_q) | s2_vld;
  assign commit = sh_pend_q && !busy && !(|in_vld);

  always_ff @(posedge sck or negedge voide_rst_n) begin
    if (!voide_rst_n) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
      for (int c = 0; c < CH_NUM; c++) begin
        samp_q[c] <= '0;
        hist_q[c] <= '0;
      end
    end else begin
      // an arrival on a channel granted straight from the wire needs no slot
      pend_q <= (pend_q & ~gnt_oh) | (take & ~(gnt_oh & ~pend_q));
      ovf_q  <= ovf_q | (|drop);
      for (int c = 0; c < CH_NUM; c++) begin
        if (take[c]) samp_q[c] <= x_in[c];
        if (commit)                              hist_q[c] <= '0;
        else if (wb_en && s2_ch == CH_W'(c))     hist_q[c] <= wb_val;
      end
    end
  end

  // commit only when the pipeline is empty so no sample mixes configs
  always_ff @(posedge sck or negedge voide_rst_n) begin
    if (!voide_rst_n) begin
      mode_q    <= EMPH_BYPASS;
      coef_q    <= COEF_RST_W;
      sh_mode_q <= EMPH_BYPASS;
      sh_coef_q <= COEF_RST_W;
      sh_pend_q <= 1'b0;
    end else begin
      if (cfg_load) begin
        sh_mode_q <= cfg_mode;
        sh_coef_q <= cfg_coef;
        sh_pend_q <= 1'b1;
      end else if (commit) begin
        sh_pend_q <= 1'b0;
      end
      if (commit) begin
        mode_q <= sh_mode_q;
        coef_q <= sh_coef_q;
      end
    end
  end

  assign ovf_err = ovf_q;

  emph_mac #(
    .DATA_WIDTH (DW),
    .COEF_WIDTH (COEF_WIDTH),
    .CH_W       (CH_W)
  ) u_mac (
    .clk       (sck),
    .rst_n     (voide_rst_n),
    .in_vld_i  (gnt_vld),
    .in_ch_i   (gnt_ch),
    .in_mode_i (mode_q),
    .in_x_i    (gnt_x),
    .in_hist_i (gnt_hist),
    .coef_i    (coef_q),
    .s2_vld_o  (s2_vld),
    .s2_ch_o   (s2_ch),
    .wb_en_o   (wb_en),
    .wb_val_o  (wb_val),
    .data_o    (data_out),
    .ch_o      (out_ch),
    .vld_o     (out_vld)
  );

endmodule

// File: tb/tb_voice_emph_filter.sv
// Directed bench: a two-channel instance checked against a behavioural
// filter model on every output strobe plus literal expectations, and a
// three-channel instance for the sample-drop case.
module tb_voice_emph_filter;

  localparam int DW = 16;
  localparam int CW = 16;

  logic sck = 1'b0;
  always #5 sck = ~sck;

  logic                 rst_n, rst3_n;
  logic [2*DW-1:0]      data_in;
  logic [1:0]           in_vld;
  logic                 cfg_load;
  logic [1:0]           cfg_mode;
  logic [CW-1:0]        cfg_coef;
  logic signed [DW-1:0] data_out;
  logic                 out_vld, out_ch, busy, ovf_err;

  logic [3*DW-1:0]      d3;
  logic [2:0]           v3;
  logic signed [DW-1:0] o3_data;
  logic                 o3_vld, busy3, ovf3;
  logic [1:0]           o3_ch;

  voice_emph_filter dut (
    .sck(sck), .voide_rst_n(rst_n), .data_in(data_in), .in_vld(in_vld),
    .cfg_load(cfg_load), .cfg_mode(cfg_mode), .cfg_coef(cfg_coef),
    .data_out(data_out), .out_vld(out_vld), .out_ch(out_ch),
    .busy(busy), .ovf_err(ovf_err)
  );

  voice_emph_filter #(.CH_NUM(3)) dut3 (
    .sck(sck), .voide_rst_n(rst3_n), .data_in(d3), .in_vld(v3),
    .cfg_load(1'b0), .cfg_mode(2'b00), .cfg_coef(16'd0),
    .data_out(o3_data), .out_vld(o3_vld), .out_ch(o3_ch),
    .busy(busy3), .ovf_err(ovf3)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int ch; int val; } exp_t;
  exp_t   exp_q[$];
  exp_t   q3[$];
  int     m_mode;
  longint m_coef;
  longint m_hist[2];

  function automatic void m_cfg(input int mode, input int coef);
    m_mode    = mode;
    m_coef    = coef;
    m_hist[0] = 0;
    m_hist[1] = 0;
  endfunction

  // y = x -/+ round(a*h), a = coef / 2^(CW-1), clamped to DW-bit range
  function automatic void m_push(input int ch, input int x);
    longint q, y;
    exp_t   e;
    q = longint'($floor(real'(m_coef * m_hist[ch]) / real'(longint'(1) << (CW-1)) + 0.5));
    case (m_mode)
      1:       y = x - q;
      2:       y = x + q;
      default: y = x;
    endcase
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    if (m_mode == 1)      m_hist[ch] = x;
    else if (m_mode == 2) m_hist[ch] = y;
    e.ch  = ch;
    e.val = int'(y);
    exp_q.push_back(e);
  endfunction

  exp_t ce;
  always @(negedge sck) begin
    if (rst_n === 1'b1 && out_vld === 1'b1) begin
      if (exp_q.size() == 0) chk("out_unexpected", out_vld, 0);
      else begin
        ce = exp_q.pop_front();
        chk("model_ch", out_ch, ce.ch);
        chk("model_data", data_out, ce.val);
      end
    end
  end

  exp_t e3;
  always @(negedge sck) begin
    if (rst3_n === 1'b1 && o3_vld === 1'b1) begin
      e3.ch  = int'(o3_ch);
      e3.val = int'(o3_data);
      q3.push_back(e3);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge sck); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) sync();
  endtask

  task automatic put(input logic [1:0] v, input int l, input int r);
    in_vld  = v;
    data_in = {DW'(r), DW'(l)};
    sync();
    in_vld  = 2'b00;
  endtask

  task automatic expect_out(input string nm, input int ch, input int val, output int n);
    n = 0;
    do begin
      @(negedge sck);
      n++;
    end while (out_vld !== 1'b1 && n < 8);
    chk({nm, "_vld"}, out_vld, 1);
    if (out_vld === 1'b1) begin
      chk({nm, "_ch"}, out_ch, ch);
      chk({nm, "_data"}, data_out, val);
    end
  endtask

  task automatic cfg(input logic [1:0] m, input int c);
    cfg_load = 1'b1;
    cfg_mode = m;
    cfg_coef = CW'(c);
    sync();
    cfg_load = 1'b0;
    idle(3);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 0; rst3_n = 0; in_vld = 0; data_in = 0;
    cfg_load = 0; cfg_mode = 0; cfg_coef = 0; v3 = 0; d3 = 0;
    m_cfg(0, 32113);
    repeat (3) @(negedge sck);
    chk("rst_data", data_out, 0);
    chk("rst_vld", out_vld, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst3_vld", o3_vld, 0);
    @(posedge sck); #1;
    rst_n = 1; rst3_n = 1;
    idle(2);

    // bypass, latency
    m_push(0, 100); put(2'b01, 100, 0);
    expect_out("byp", 0, 100, n); chk("byp_latency", n, 2);
    sync();

    // simultaneous strobes: ascending channel order, back-to-back
    m_push(0, 5); m_push(1, -7); put(2'b11, 5, -7);
    expect_out("sim_l", 0, 5, n);  chk("sim_l_latency", n, 2);
    expect_out("sim_r", 1, -7, n); chk("sim_r_next", n, 1);
    sync();

    // pre-emphasis a=0.98
    cfg(2'b01, 32113); m_cfg(1, 32113);
    m_push(0, 1000); put(2'b01, 1000, 0); expect_out("pre1", 0, 1000, n);
    idle(8);
    m_push(0, 1000); put(2'b01, 1000, 0); expect_out("pre2", 0, 20, n);
    sync();
    m_push(1, 1000); put(2'b10, 0, 1000); expect_out("pre_r", 1, 1000, n);
    sync();

    // de-emphasis saturation high, then low from cleared history
    cfg(2'b10, 32113); m_cfg(2, 32113);
    m_push(0, 32767); put(2'b01, 32767, 0); expect_out("de1", 0, 32767, n);
    idle(3);
    m_push(0, 32767); put(2'b01, 32767, 0); expect_out("de_sat_hi", 0, 32767, n);
    sync();
    cfg(2'b10, 32113); m_cfg(2, 32113);
    m_push(0, -32768); put(2'b01, -32768, 0); expect_out("de_neg1", 0, -32768, n);
    idle(3);
    m_push(0, -32768); put(2'b01, -32768, 0); expect_out("de_sat_lo", 0, -32768, n);
    sync();

    // cfg_load while a sample is in flight: old config still applies
    m_push(0, 50); put(2'b01, 50, 0);
    cfg_load = 1'b1; cfg_mode = 2'b01; cfg_coef = 16'd16384;
    @(negedge sck); chk("cfg_busy", busy, 1);
    @(posedge sck); #1; cfg_load = 1'b0;
    expect_out("cfg_old", 0, -32063, n); chk("cfg_old_latency", n, 1);
    sync(); idle(3);
    m_cfg(1, 16384);
    m_push(0, 200); put(2'b01, 200, 0); expect_out("cfg_new1", 0, 200, n);
    sync(); idle(2);
    m_push(0, 200); put(2'b01, 200, 0); expect_out("cfg_new2", 0, 100, n);
    sync();

    // back-to-back on one channel exercises history forwarding
    m_push(0, 400); m_push(0, 600);
    put(2'b01, 400, 0); put(2'b01, 600, 0);
    expect_out("fwd1", 0, 300, n);
    expect_out("fwd2", 0, 400, n); chk("fwd2_next", n, 1);
    sync();

    // three channels: second ch2 strobe while ch2 still waiting is dropped
    v3 = 3'b111; d3 = {DW'(30), DW'(20), DW'(10)};
    sync();
    v3 = 3'b100; d3 = {DW'(99), DW'(0), DW'(0)};
    @(negedge sck); chk("ovf_t1", ovf3, 0);
    @(posedge sck); #1; v3 = 3'b000;
    @(negedge sck); chk("ovf_t2", ovf3, 1);
    sync(); idle(6);
    chk("ovf_count", q3.size(), 3);
    for (int i = 0; i < 3 && i < q3.size(); i++) begin
      chk("ovf_out_ch", q3[i].ch, i);
      chk("ovf_out_data", q3[i].val, 10 * (i + 1));
    end
    chk("ovf_sticky", ovf3, 1);
    chk("ovf_main_clear", ovf_err, 0);

    // reset while a sample is in flight
    put(2'b01, 123, 0);
    rst_n = 0;
    @(negedge sck);
    chk("mid_rst_vld", out_vld, 0);
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_ch", out_ch, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge sck); #1; rst_n = 1;
    repeat (4) begin
      @(negedge sck);
      chk("mid_rst_no_out", out_vld, 0);
    end
    chk("model_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/voice_emph_filter.md
# voice_emph_filter

Parametrised multi-channel first-order emphasis filter for the audio path. It replaces the fixed single-coefficient pre-emphasis stage and supports three modes:

- bypass;
- pre-emphasis, y[n]=x[n]−a·x[n−1];
- de-emphasis, y[n]=x[n]+a·y[n−1].

It has a runtime coefficient, per-channel history and saturation. It sits between the I2S receiver and the downstream voice-change and FIFO stages. Samples from all channels are serialised through one shared multiplier pipeline.

## Interface
- DATA_WIDTH, 16: signed two's-complement sample width.
- COEF_WIDTH, 16: unsigned coefficient width, format Q1.(COEF_WIDTH−1), range [0,1).
- CH_NUM, 2: channel count; ch0 = left, ch1 = right.
- COEF_RST, 32113: coefficient after reset (0.98 in Q1.15).
- CH_W = max(1, clog2(CH_NUM)): derived localparam.

Ports:
- sck  in  1  audio bit/system clock; the only clock.
- voide_rst_n  in  1  asynchronous active-low reset.
- data_in  in  CH_NUM·DATA_WIDTH  packed samples; channel c occupies bits [c·DATA_WIDTH +: DATA_WIDTH].
- in_vld  in  CH_NUM  per-channel one-cycle sample strobe; any combination may be high at once.
- cfg_load  in  1  one-cycle strobe that captures cfg_mode and cfg_coef into the shadow registers.
- cfg_mode  in  2  mode: 00 bypass, 01 pre-emphasis, 10 de-emphasis, 11 treated as bypass.
- cfg_coef  in  COEF_WIDTH  coefficient a.
- data_out  out  DATA_WIDTH  filtered sample.
- out_vld  out  1  one-cycle strobe qualifying data_out and out_ch.
- out_ch  out  CH_W  channel index of data_out.
- busy  out  1  high while any sample is pending or in flight.
- ovf_err  out  1  sticky sample-drop flag.

## Operation
- Each channel has a pending bit and a sample register. An in_vld[c] strobe latches data_in[c] and sets pending[c].
- Arbiter: every cycle it grants the lowest-index channel among pending | in_vld. The grant clears that channel's pending bit. An incoming sample may be granted in its own arrival cycle.
- Overflow: in_vld[c] arrives while pending[c] is set and c is not granted that cycle.
  - The new sample is dropped and the held sample is kept.
  - ovf_err is set. It clears only on reset.
- Stage 1 (grant cycle): compute p = a·hist[c] at full width, DATA_WIDTH+COEF_WIDTH+1 signed. Register p, x, c and the mode.
- Stage 2: round p with q = (p + 2^(COEF_WIDTH−2)) >>> (COEF_WIDTH−1), arithmetic shift. Then form x−q (pre) or x+q (de) at DATA_WIDTH+2 bits and saturate to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - In bypass, y = x.
  - Stage 2 registers data_out, out_ch and out_vld.
- History update at stage 2: hist[c] takes x in pre-emphasis mode and the saturated y in de-emphasis mode. It is unchanged in bypass.
- Forwarding: if stage 1 and stage 2 hold the same channel, stage 1 uses the history value being written by stage 2, not the stale register.
- Configuration:
  - cfg_load writes the shadow registers. A second cfg_load before commit overwrites the shadow.
  - The shadow commits to the active mode/coef on the first cycle in which busy is low and no in_vld is high.
  - Commit clears every hist[c] to 0.
  - A sample never sees a mixed old/new configuration.
- Reset clears pending bits, history, the pipeline, data_out, out_vld, out_ch, busy and ovf_err to 0. Mode resets to bypass and the coefficient to COEF_RST.
  - Asserting reset mid-operation discards in-flight samples with no output strobe.

## Timing
- Latency: in_vld at cycle T with no contention gives out_vld at T+2.
- Throughput: one sample per cycle, all channels combined.
- A channel that waits k cycles for its grant emerges at T+2+k.
- With simultaneous strobes on all channels, outputs appear on consecutive cycles in ascending channel order.
- Sustainable per-channel input rate: at most one sample per CH_NUM cycles without risk of drop.
- cfg_load commit takes effect on the first grant after the idle cycle.

## Structure
- Package voice_emph_pkg holds:
  - the mode encodings EMPH_BYPASS, EMPH_PRE and EMPH_DE;
  - the rounding constant;
  - the saturation-limit functions.
- Sub-module emph_mac: registered multiply, round/add/sub and saturate datapath, shared by all channels.
- The top level holds the arbiter, pending logic, per-channel history, forwarding and config shadowing.

## Test plan
All scenarios use defaults unless stated; T is the strobe cycle.
- Bypass: in_vld=01, L=100 at T → out_vld at T+2, data_out=100, out_ch=0.
- Pre-emphasis, a=32113: L=1000 twice, 10 cycles apart → outputs 1000, then 20.
- Simultaneous channels: in_vld=11 at T with L=5, R=−7 in bypass → L=5 at T+2, R=−7 at T+3.
- De-emphasis saturation: L=32767 twice → outputs 32767 and 32767 (clamped).
  - Then −32768 twice from cleared history → outputs −32768 and −32768.
- Overflow, CH_NUM=3: in_vld=111 at T, in_vld=100 at T+1 → ch2's second sample dropped, ovf_err=1 at T+2. Three outputs only, the ch2 one carrying the first value.
- Config during traffic: cfg_load (pre, a=16384) while busy → no effect until idle. Next L=200 then 200 → outputs 200, then 100.
- Reset mid-operation: reset pulse at T+1 → no out_vld; all outputs read 0.
